// File: rtl/board_level_frame_decoder.sv
// Tagged-symbol frame decoder: classifies raw symbols, tracks start/data/end
// framing, counts payload per frame and reports violations as pulses and sticky flags.
module board_level_frame_decoder #(
    parameter int SYMBOL_WIDTH  = 8,
    parameter int MAX_FRAME_LEN = 256,
    parameter int LEN_WIDTH     = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SYMBOL_WIDTH-1:0] raw_data,
    input  logic                    raw_data_valid,
    input  logic                    err_clear,
    output logic                    frame_start,
    output logic                    frame_end,
    output logic                    frame_abort,
    output logic [SYMBOL_WIDTH-3:0] decoded_data,
    output logic                    decoded_data_valid,
    output logic [LEN_WIDTH-1:0]    frame_len,
    output logic [3:0]              error_flags
);

    // Handshake: raw_data is consumed on every rising edge where raw_data_valid=1;
    // there is no backpressure, and decoded_data_valid qualifies decoded_data for
    // exactly one cycle with no ready from the consumer.

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_IN_FRAME = 2'd1,
        S_DISCARD  = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_FRAME_LEN);

    state_t                  state, state_n;
    logic [LEN_WIDTH-1:0]    count, count_n;
    logic                    start_n, end_n, abort_n, dv_n;
    logic [SYMBOL_WIDTH-3:0] dd_n;
    logic [LEN_WIDTH-1:0]    flen_n;
    logic [3:0]              flags_n;

    logic is_fill, is_start, is_end, is_data, is_illegal;

    always_comb begin
        is_fill    = (raw_data == SYMBOL_WIDTH'(0));
        is_start   = (raw_data == SYMBOL_WIDTH'(1));
        is_end     = (raw_data == SYMBOL_WIDTH'(2));
        is_data    = (raw_data[1:0] == 2'b11);
        is_illegal = !(is_fill || is_start || is_end || is_data);
    end

    always_comb begin
        state_n = state;
        count_n = count;
        start_n = 1'b0;
        end_n   = 1'b0;
        abort_n = 1'b0;
        dv_n    = 1'b0;
        dd_n    = '0;
        flen_n  = frame_len;
        // A fresh error on a clearing cycle survives because it is OR-ed in after the clear.
        flags_n = err_clear ? 4'b0000 : error_flags;

        if (raw_data_valid && !is_fill) begin
            case (state)
                S_IDLE: begin
                    if (is_start) begin
                        start_n = 1'b1;
                        count_n = '0;
                        state_n = S_IN_FRAME;
                    end else if (is_data || is_end) begin
                        flags_n[0] = 1'b1;
                    end else begin
                        flags_n[3] = 1'b1;
                    end
                end
                S_IN_FRAME: begin
                    if (is_data) begin
                        if (count < MAX_LEN) begin
                            dv_n    = 1'b1;
                            dd_n    = raw_data[SYMBOL_WIDTH-1:2];
                            count_n = count + 1'b1;
                        end else begin
                            flags_n[2] = 1'b1;
                            abort_n    = 1'b1;
                            state_n    = S_DISCARD;
                        end
                    end else if (is_end) begin
                        end_n   = 1'b1;
                        flen_n  = count;
                        state_n = S_IDLE;
                    end else if (is_start) begin
                        flags_n[1] = 1'b1;
                        abort_n    = 1'b1;
                        start_n    = 1'b1;
                        count_n    = '0;
                    end else begin
                        flags_n[3] = 1'b1;
                        abort_n    = 1'b1;
                        state_n    = S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (is_start) begin
                        start_n = 1'b1;
                        count_n = '0;
                        state_n = S_IN_FRAME;
                    end else if (is_end) begin
                        state_n = S_IDLE;
                    end else if (is_illegal) begin
                        flags_n[3] = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_IDLE;
            count              <= '0;
            frame_start        <= 1'b0;
            frame_end          <= 1'b0;
            frame_abort        <= 1'b0;
            decoded_data_valid <= 1'b0;
            decoded_data       <= '0;
            frame_len          <= '0;
            error_flags        <= 4'b0000;
        end else begin
            state              <= state_n;
            count              <= count_n;
            frame_start        <= start_n;
            frame_end          <= end_n;
            frame_abort        <= abort_n;
            decoded_data_valid <= dv_n;
            decoded_data       <= dd_n;
            frame_len          <= flen_n;
            error_flags        <= flags_n;
        end
    end

endmodule

// File: tb/tb_board_level_frame_decoder.sv
// Directed bench for board_level_frame_decoder: a vector table of
// {controls, symbol, expected outputs} plus hand-written length-limit sequences.
module tb_board_level_frame_decoder;

    localparam int SW   = 8;
    localparam int MAXL = 4;
    localparam int LW   = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] raw_data;
    logic          raw_data_valid;
    logic          err_clear;
    logic          frame_start, frame_end, frame_abort;
    logic [SW-3:0] decoded_data;
    logic          decoded_data_valid;
    logic [LW-1:0] frame_len;
    logic [3:0]    error_flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          rst;
        logic          v;
        logic          clr;
        logic [SW-1:0] data;
        logic          s;
        logic          e;
        logic          a;
        logic          dv;
        logic [SW-3:0] dd;
        logic [LW-1:0] flen;
        logic [3:0]    flags;
    } vec_t;

    vec_t vecs[$];

    board_level_frame_decoder #(
        .SYMBOL_WIDTH (SW),
        .MAX_FRAME_LEN(MAXL),
        .LEN_WIDTH    (LW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .raw_data          (raw_data),
        .raw_data_valid    (raw_data_valid),
        .err_clear         (err_clear),
        .frame_start       (frame_start),
        .frame_end         (frame_end),
        .frame_abort       (frame_abort),
        .decoded_data      (decoded_data),
        .decoded_data_valid(decoded_data_valid),
        .frame_len         (frame_len),
        .error_flags       (error_flags)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic v, input logic c, input logic [SW-1:0] d,
                       input logic s, input logic e, input logic a, input logic dv,
                       input logic [SW-3:0] dd, input logic [LW-1:0] fl, input logic [3:0] f);
        vec_t x;
        x.rst = r; x.v = v; x.clr = c; x.data = d;
        x.s = s; x.e = e; x.a = a; x.dv = dv; x.dd = dd; x.flen = fl; x.flags = f;
        vecs.push_back(x);
    endtask

    task automatic chk(input string tag, input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h", tag, name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then sample 1 time unit after the edge.
    task automatic drive(input logic r, input logic v, input logic c, input logic [SW-1:0] d);
        rst = r; raw_data_valid = v; err_clear = c; raw_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic s, input logic e, input logic a,
                              input logic dv, input logic [SW-3:0] dd, input logic [LW-1:0] fl,
                              input logic [3:0] f);
        chk(tag, "frame_start", 32'(frame_start), 32'(s));
        chk(tag, "frame_end", 32'(frame_end), 32'(e));
        chk(tag, "frame_abort", 32'(frame_abort), 32'(a));
        chk(tag, "decoded_data_valid", 32'(decoded_data_valid), 32'(dv));
        chk(tag, "decoded_data", 32'(decoded_data), 32'(dd));
        chk(tag, "frame_len", 32'(frame_len), 32'(fl));
        chk(tag, "error_flags", 32'(error_flags), 32'(f));
    endtask

    initial begin
        rst = 1'b1; raw_data_valid = 1'b0; err_clear = 1'b0; raw_data = '0;

        //   rst v clr data    s e a dv dd     flen flags
        add(1, 0, 0, 8'h00,  0,0,0,0, 6'h00, 9'd0, 4'b0000); // reset state
        // clean frame with two payloads
        add(0, 1, 0, 8'h01,  1,0,0,0, 6'h00, 9'd0, 4'b0000);
        add(0, 1, 0, 8'hAF,  0,0,0,1, 6'h2B, 9'd0, 4'b0000);
        add(0, 1, 0, 8'h07,  0,0,0,1, 6'h01, 9'd0, 4'b0000);
        add(0, 1, 0, 8'h02,  0,1,0,0, 6'h00, 9'd2, 4'b0000);
        // overflow on fifth data symbol, END in DISCARD is silent
        add(0, 1, 0, 8'h01,  1,0,0,0, 6'h00, 9'd2, 4'b0000);
        add(0, 1, 0, 8'h03,  0,0,0,1, 6'h00, 9'd2, 4'b0000);
        add(0, 1, 0, 8'h03,  0,0,0,1, 6'h00, 9'd2, 4'b0000);
        add(0, 1, 0, 8'h03,  0,0,0,1, 6'h00, 9'd2, 4'b0000);
        add(0, 1, 0, 8'h03,  0,0,0,1, 6'h00, 9'd2, 4'b0000);
        add(0, 1, 0, 8'h03,  0,0,1,0, 6'h00, 9'd2, 4'b0100);
        add(0, 1, 0, 8'h02,  0,0,0,0, 6'h00, 9'd2, 4'b0100);
        add(0, 1, 0, 8'h01,  1,0,0,0, 6'h00, 9'd2, 4'b0100);
        add(0, 1, 0, 8'h02,  0,1,0,0, 6'h00, 9'd0, 4'b0100);
        add(0, 0, 1, 8'h00,  0,0,0,0, 6'h00, 9'd0, 4'b0000);
        // orphans in IDLE, then clear
        add(0, 1, 0, 8'h03,  0,0,0,0, 6'h00, 9'd0, 4'b0001);
        add(0, 1, 0, 8'h02,  0,0,0,0, 6'h00, 9'd0, 4'b0001);
        add(0, 0, 1, 8'h00,  0,0,0,0, 6'h00, 9'd0, 4'b0000);
        // restart inside a frame
        add(0, 1, 0, 8'h01,  1,0,0,0, 6'h00, 9'd0, 4'b0000);
        add(0, 1, 0, 8'h03,  0,0,0,1, 6'h00, 9'd0, 4'b0000);
        add(0, 1, 0, 8'h01,  1,0,1,0, 6'h00, 9'd0, 4'b0010);
        add(0, 1, 0, 8'h02,  0,1,0,0, 6'h00, 9'd0, 4'b0010);
        // gaps in valid, then illegal in frame
        add(0, 1, 0, 8'h01,  1,0,0,0, 6'h00, 9'd0, 4'b0010);
        add(0, 1, 0, 8'h07,  0,0,0,1, 6'h01, 9'd0, 4'b0010);
        add(0, 0, 0, 8'h07,  0,0,0,0, 6'h00, 9'd0, 4'b0010);
        add(0, 0, 0, 8'h05,  0,0,0,0, 6'h00, 9'd0, 4'b0010);
        add(0, 0, 0, 8'h02,  0,0,0,0, 6'h00, 9'd0, 4'b0010);
        add(0, 1, 0, 8'h0B,  0,0,0,1, 6'h02, 9'd0, 4'b0010);
        add(0, 1, 0, 8'h02,  0,1,0,0, 6'h00, 9'd2, 4'b0010);
        add(0, 1, 0, 8'h01,  1,0,0,0, 6'h00, 9'd2, 4'b0010);
        add(0, 1, 0, 8'h05,  0,0,1,0, 6'h00, 9'd2, 4'b1010);
        add(0, 1, 0, 8'h03,  0,0,0,0, 6'h00, 9'd2, 4'b1010);
        add(0, 1, 1, 8'h06,  0,0,0,0, 6'h00, 9'd2, 4'b1000); // clear with new illegal
        add(0, 1, 0, 8'h01,  1,0,0,0, 6'h00, 9'd2, 4'b1000);
        add(0, 1, 0, 8'h00,  0,0,0,0, 6'h00, 9'd2, 4'b1000); // FILL ignored
        add(0, 1, 0, 8'h02,  0,1,0,0, 6'h00, 9'd0, 4'b1000);
        // reset mid-frame
        add(0, 1, 0, 8'h01,  1,0,0,0, 6'h00, 9'd0, 4'b1000);
        add(0, 1, 0, 8'h03,  0,0,0,1, 6'h00, 9'd0, 4'b1000);
        add(0, 1, 0, 8'h02,  0,1,0,0, 6'h00, 9'd1, 4'b1000);
        add(0, 1, 0, 8'h01,  1,0,0,0, 6'h00, 9'd1, 4'b1000);
        add(0, 1, 0, 8'h03,  0,0,0,1, 6'h00, 9'd1, 4'b1000);
        add(1, 1, 0, 8'h01,  0,0,0,0, 6'h00, 9'd0, 4'b0000);
        add(0, 1, 0, 8'h03,  0,0,0,0, 6'h00, 9'd0, 4'b0001);
        add(0, 1, 0, 8'h02,  0,0,0,0, 6'h00, 9'd0, 4'b0001);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].clr, vecs[i].data);
            expect_out($sformatf("row%0d", i), vecs[i].s, vecs[i].e, vecs[i].a, vecs[i].dv,
                       vecs[i].dd, vecs[i].flen, vecs[i].flags);
        end

        // Frame of exactly MAX_FRAME_LEN payloads closes cleanly.
        drive(0, 0, 1, 8'h00);
        expect_out("full_clr", 0, 0, 0, 0, 6'h00, 9'd0, 4'b0000);
        drive(0, 1, 0, 8'h01);
        expect_out("full_start", 1, 0, 0, 0, 6'h00, 9'd0, 4'b0000);
        for (int k = 0; k < MAXL; k++) begin
            drive(0, 1, 0, 8'h13 + 8'(4 * k));
            expect_out($sformatf("full_d%0d", k), 0, 0, 0, 1, 6'(4 + k), 9'd0, 4'b0000);
        end
        drive(0, 1, 0, 8'h02);
        expect_out("full_end", 0, 1, 0, 0, 6'h00, 9'd4, 4'b0000);

        // Overflow: extra data in DISCARD produces nothing, counter restarts on START.
        drive(0, 1, 0, 8'h01);
        expect_out("ovf_start", 1, 0, 0, 0, 6'h00, 9'd4, 4'b0000);
        for (int k = 0; k < MAXL; k++) begin
            drive(0, 1, 0, 8'hFF);
            expect_out($sformatf("ovf_d%0d", k), 0, 0, 0, 1, 6'h3F, 9'd4, 4'b0000);
        end
        drive(0, 1, 0, 8'hFF);
        expect_out("ovf_abort", 0, 0, 1, 0, 6'h00, 9'd4, 4'b0100);
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 0, 8'hFF);
            expect_out($sformatf("ovf_drop%0d", k), 0, 0, 0, 0, 6'h00, 9'd4, 4'b0100);
        end
        drive(0, 1, 0, 8'h02);
        expect_out("ovf_end", 0, 0, 0, 0, 6'h00, 9'd4, 4'b0100);
        drive(0, 1, 0, 8'h01);
        expect_out("ovf_restart", 1, 0, 0, 0, 6'h00, 9'd4, 4'b0100);
        drive(0, 1, 0, 8'h02);
        expect_out("ovf_empty_end", 0, 1, 0, 0, 6'h00, 9'd0, 4'b0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
